acl_pkt_fifo: RTL and testbench

//   Parametrised store-and-forward packet FIFO between the AXI-S RX MAC interface and the ACL rule engine.

---
 rtl/acl_pkt_fifo.sv | 151 +++++++++++++++
 tb/tb_acl_pkt_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acl_pkt_fifo.sv
`timescale 1ns/1ps
// Store-and-forward packet FIFO: a frame becomes readable only after its tlast beat commits.
// Discarded and oversize frames are rolled back, so their words never reach the read side.
module acl_pkt_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int AFULL_THR  = 480
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_rxd_tvalid,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic                  i_rx_tlast,
   output logic                  o_rxd_tready,
   input  logic                  i_frame_drop,
   output logic [DATA_WIDTH-1:0] o_tdata,
   output logic                  o_tvalid,
   output logic                  o_tlast,
   input  logic                  i_tready,
   output logic [ADDR_WIDTH:0]   o_wr_cnt,
   output logic [ADDR_WIDTH:0]   o_frame_cnt,
   output logic                  o_afull,
   output logic                  o_ovf_drop
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH_C = PW'(2 ** ADDR_WIDTH);
   localparam logic [PW-1:0] AFULL_C = PW'(AFULL_THR);
   localparam logic [PW-1:0] ONE_C   = PW'(1);

   logic [DATA_WIDTH:0]   mem_r [2 ** ADDR_WIDTH];
   logic [PW-1:0]         wr_ptr_r, cm_ptr_r, rd_ptr_r, fe_ptr_r, wr_cnt_r, frame_cnt_r;
   logic                  drop_pend_r, trunc_r, rdy_r, afull_r, ovf_r, tvalid_r, tlast_r;
   logic [DATA_WIDTH-1:0] tdata_r;

   logic                  full_s, acc_s, wr_en_s, last_s, rollback_s, commit_s, ovf_s;
   logic                  load_s, xfer_s, trunc_nxt_s;
   logic [PW-1:0]         wr_ptr_nxt_s, rd_ptr_nxt_s, cnt_nxt_s;
   logic [DATA_WIDTH:0]   rd_word_s;

   // Handshake decode and next-state pointers; rd_ptr advances on output transfer, fe_ptr on prefetch
   always_comb begin
      full_s     = (wr_cnt_r == DEPTH_C);
      acc_s      = i_rxd_tvalid && rdy_r;
      wr_en_s    = acc_s && !trunc_r;
      last_s     = wr_en_s && i_rx_tlast;
      rollback_s = last_s && (drop_pend_r || i_frame_drop);
      commit_s   = last_s && !rollback_s;
      // The frame alone fills the buffer and nothing committed is left to drain: it can never fit
      ovf_s      = i_rxd_tvalid && full_s && !trunc_r && (cm_ptr_r == rd_ptr_r);
      load_s     = (!tvalid_r || i_tready) && (fe_ptr_r != cm_ptr_r);
      xfer_s     = tvalid_r && i_tready;
      rd_word_s  = mem_r[fe_ptr_r[ADDR_WIDTH-1:0]];
      if (ovf_s || rollback_s) begin
         wr_ptr_nxt_s = cm_ptr_r;
      end else if (wr_en_s) begin
         wr_ptr_nxt_s = wr_ptr_r + ONE_C;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (xfer_s) begin
         rd_ptr_nxt_s = rd_ptr_r + ONE_C;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      if (ovf_s) begin
         trunc_nxt_s = 1'b1;
      end else if (acc_s && trunc_r && i_rx_tlast) begin
         trunc_nxt_s = 1'b0;
      end else begin
         trunc_nxt_s = trunc_r;
      end
      cnt_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
   end

   // Write-side pointers, frame state and registered ready/occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r    <= '0;
         cm_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         wr_cnt_r    <= '0;
         drop_pend_r <= 1'b0;
         trunc_r     <= 1'b0;
         rdy_r       <= 1'b0;
         afull_r     <= 1'b0;
         ovf_r       <= 1'b0;
      end else begin
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         wr_cnt_r <= cnt_nxt_s;
         trunc_r  <= trunc_nxt_s;
         rdy_r    <= (cnt_nxt_s != DEPTH_C) || trunc_nxt_s;
         afull_r  <= (wr_cnt_r >= AFULL_C);
         ovf_r    <= ovf_s;
         if (commit_s) begin
            cm_ptr_r <= wr_ptr_r + ONE_C;
         end
         if (acc_s && i_rx_tlast) begin
            drop_pend_r <= 1'b0;
         end else if (acc_s && i_frame_drop) begin
            drop_pend_r <= 1'b1;
         end
      end
   end

   // Committed-frame count: +1 per commit, -1 per transferred tlast beat
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt_r <= '0;
      end else begin
         case ({commit_s, xfer_s && tlast_r})
            2'b10:   frame_cnt_r <= frame_cnt_r + ONE_C;
            2'b01:   frame_cnt_r <= frame_cnt_r - ONE_C;
            default: frame_cnt_r <= frame_cnt_r;
         endcase
      end
   end

   // First-word-fall-through output register fed from committed words only
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fe_ptr_r <= '0;
         tvalid_r <= 1'b0;
         tlast_r  <= 1'b0;
         tdata_r  <= '0;
      end else if (load_s) begin
         fe_ptr_r <= fe_ptr_r + ONE_C;
         tvalid_r <= 1'b1;
         tlast_r  <= rd_word_s[DATA_WIDTH];
         tdata_r  <= rd_word_s[DATA_WIDTH-1:0];
      end else if (i_tready) begin
         tvalid_r <= 1'b0;
      end
   end

   // Frame storage, tlast kept alongside the data word
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= {i_rx_tlast, i_rx_data};
      end
   end

   assign o_rxd_tready = rdy_r;
   assign o_tdata      = tdata_r;
   assign o_tvalid     = tvalid_r;
   assign o_tlast      = tlast_r;
   assign o_wr_cnt     = wr_cnt_r;
   assign o_frame_cnt  = frame_cnt_r;
   assign o_afull      = afull_r;
   assign o_ovf_drop   = ovf_r;
endmodule

// File: tb/tb_acl_pkt_fifo.sv
`timescale 1ns/1ps
// Randomized bench for acl_pkt_fifo: a frame-level scoreboard predicts output words,
// frame count, occupancy, ready and almost-full every cycle.
module tb_acl_pkt_fifo;
   localparam int DW    = 32;
   localparam int AW    = 9;
   localparam int DEPTH = 512;
   localparam int THR   = 480;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_rxd_tvalid, i_rx_tlast, i_frame_drop, i_tready;
   logic [DW-1:0] i_rx_data;
   logic          o_rxd_tready, o_tvalid, o_tlast, o_afull, o_ovf_drop;
   logic [DW-1:0] o_tdata;
   logic [AW:0]   o_wr_cnt, o_frame_cnt;

   acl_pkt_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THR(THR)) dut (
      .clk(clk), .rst(rst),
      .i_rxd_tvalid(i_rxd_tvalid), .i_rx_data(i_rx_data), .i_rx_tlast(i_rx_tlast),
      .o_rxd_tready(o_rxd_tready), .i_frame_drop(i_frame_drop),
      .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .i_tready(i_tready),
      .o_wr_cnt(o_wr_cnt), .o_frame_cnt(o_frame_cnt), .o_afull(o_afull), .o_ovf_drop(o_ovf_drop)
   );

   always #5 clk = ~clk;

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: committed-unread words, the frame being written, frame count
   logic [DW:0] exp_q[$];
   logic [DW:0] cur_q[$];
   logic [DW:0] w;
   bit          cur_drop = 1'b0;
   bit          exp_afull = 1'b0;
   bit          chk_occ = 1'b1;
   bit          rst_e = 1'b0;
   int          fc = 0, occ = 0, ovf_seen = 0, ovf_exp = 0, peak_obs = 0, rd_mode = 0;

   initial begin
      forever begin
         @(posedge clk);
         rst_e = rst;
         if (rst) begin
            exp_afull = ((exp_q.size() + cur_q.size()) >= THR);
            if (o_tvalid && i_tready) begin
               chk_eq("out_avail", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  w = exp_q.pop_front();
                  chk_eq("out_word", {o_tlast, o_tdata}, w);
                  if (w[DW]) fc--;
               end
            end
            if (o_ovf_drop) ovf_seen++;
            if (i_rxd_tvalid && o_rxd_tready) begin
               cur_q.push_back({i_rx_tlast, i_rx_data});
               if (i_frame_drop) cur_drop = 1'b1;
               if (i_rx_tlast) begin
                  if (cur_q.size() > DEPTH) begin
                     ovf_exp++;
                  end else if (!cur_drop) begin
                     foreach (cur_q[k]) exp_q.push_back(cur_q[k]);
                     fc++;
                  end
                  cur_q.delete();
                  cur_drop = 1'b0;
               end
            end
         end
         #2;
         if (!rst || !rst_e) begin
            exp_q.delete();
            cur_q.delete();
            cur_drop  = 1'b0;
            fc        = 0;
            exp_afull = 1'b0;
            if (!rst)
               chk_eq("rst_outs", {o_tvalid, o_tlast, o_afull, o_ovf_drop, o_rxd_tready,
                                   o_wr_cnt, o_frame_cnt, o_tdata}, 64'd0);
         end else begin
            occ = exp_q.size() + cur_q.size();
            chk_eq("frame_cnt", o_frame_cnt, fc);
            if (int'(o_frame_cnt) > peak_obs) peak_obs = int'(o_frame_cnt);
            if (chk_occ) begin
               chk_eq("wr_cnt", o_wr_cnt, occ);
               chk_eq("tready", o_rxd_tready, occ != DEPTH);
               chk_eq("afull", o_afull, exp_afull);
            end
         end
      end
   end

   // Read-side ready: 0 = stalled, 1 = always ready, 2 = random
   initial begin
      i_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rd_mode)
            0:       i_tready = 1'b0;
            1:       i_tready = 1'b1;
            default: i_tready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // Called #1 after a rising edge; returns #1 after the edge that accepted the beat
   task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic drop);
      i_rxd_tvalid = 1'b1;
      i_rx_data    = d;
      i_rx_tlast   = last;
      i_frame_drop = drop;
      for (int k = 0; k < 4000 && !o_rxd_tready; k++) begin
         @(posedge clk);
         #1;
      end
      if (!o_rxd_tready) chk_eq("wr_ready_timeout", o_rxd_tready, 1'b1);
      @(posedge clk);
      #1;
      i_rxd_tvalid = 1'b0;
      i_rx_tlast   = 1'b0;
      i_frame_drop = 1'b0;
      i_rx_data    = $urandom;
   endtask

   task automatic send_frame(input int len, input int drop_at, input logic [DW-1:0] base,
                             input bit rnd, input int gap_max);
      logic [DW-1:0] d;
      for (int i = 1; i <= len; i++) begin
         repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
         end
         d = rnd ? $urandom : base + 32'(i - 1);
         send_beat(d, i == len, i == drop_at);
      end
   endtask

   task automatic wait_drain(input string tag);
      for (int k = 0; k < 5000 && (exp_q.size() != 0 || o_tvalid); k++) begin
         @(posedge clk);
         #1;
      end
      chk_eq(tag, exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int len, dpos;

   initial begin
      rst = 1'b0;
      i_rxd_tvalid = 1'b0;
      i_rx_tlast   = 1'b0;
      i_frame_drop = 1'b0;
      i_rx_data    = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_tvalid", o_tvalid, 1'b0);
      chk_eq("rst_tready", o_rxd_tready, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_eq("rel_tready", o_rxd_tready, 1'b1);
      chk_eq("rel_wr_cnt", o_wr_cnt, 10'd0);

      // 16-word frame, FWFT latency and in-order readout
      rd_mode = 1;
      @(posedge clk);
      #1;
      send_frame(16, 0, 32'h1, 1'b0, 0);
      chk_eq("t1_fc_commit", o_frame_cnt, 10'd1);
      chk_eq("t1_lat1", o_tvalid, 1'b0);
      @(posedge clk);
      #1;
      chk_eq("t1_lat2", o_tvalid, 1'b1);
      chk_eq("t1_first", o_tdata, 32'h1);
      wait_drain("t1_drain");
      chk_eq("t1_fc_end", o_frame_cnt, 10'd0);

      // Dropped 20-word frame followed by a good 4-word frame
      peak_obs = 0;
      send_frame(20, 5, 32'h100, 1'b0, 0);
      send_frame(4, 0, 32'hA, 1'b0, 0);
      wait_drain("t2_drain");
      chk_eq("t2_wr_cnt", o_wr_cnt, 10'd0);
      chk_eq("t2_peak_fc", peak_obs, 1);

      // Fill with 512 single-beat frames while the reader is stalled
      rd_mode = 0;
      for (int i = 0; i < DEPTH; i++) send_beat(32'h3000 + 32'(i), 1'b1, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk_eq("t3_wr_cnt", o_wr_cnt, 10'd512);
      chk_eq("t3_tready", o_rxd_tready, 1'b0);
      chk_eq("t3_afull", o_afull, 1'b1);
      chk_eq("t3_fc", o_frame_cnt, 10'd512);
      rd_mode = 1;
      wait_drain("t3_drain");
      @(posedge clk);
      #1;
      chk_eq("t3_tready_back", o_rxd_tready, 1'b1);
      chk_eq("t3_wr_cnt_end", o_wr_cnt, 10'd0);

      // Oversize 600-word frame, then a 3-word frame
      chk_occ  = 1'b0;
      ovf_seen = 0;
      ovf_exp  = 0;
      send_frame(600, 0, 32'h5000, 1'b0, 0);
      @(posedge clk);
      #1;
      chk_occ = 1'b1;
      chk_eq("t4_ovf_model", ovf_seen, ovf_exp);
      chk_eq("t4_ovf_once", ovf_seen, 1);
      chk_eq("t4_wr_cnt", o_wr_cnt, 10'd0);
      chk_eq("t4_no_out", o_tvalid, 1'b0);
      send_frame(3, 0, 32'h6000, 1'b0, 0);
      wait_drain("t4_drain");
      chk_eq("t4_fc_end", o_frame_cnt, 10'd0);

      // Random back-to-back frames, random drops and random read stalls
      rd_mode = 2;
      for (int f = 0; f < 40; f++) begin
         len  = $urandom_range(1, 40);
         dpos = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
         send_frame(len, dpos, 32'h0, 1'b1, 2);
      end
      rd_mode = 1;
      wait_drain("t5_drain");
      chk_eq("t5_fc_end", o_frame_cnt, 10'd0);
      chk_eq("t5_wr_cnt_end", o_wr_cnt, 10'd0);

      // Reset in the middle of a frame with a committed frame still unread
      rd_mode = 0;
      send_frame(5, 0, 32'h7000, 1'b0, 0);
      for (int i = 1; i <= 7; i++) send_beat(32'h7100 + 32'(i), 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      chk_eq("t6_tvalid", o_tvalid, 1'b0);
      chk_eq("t6_wr_cnt", o_wr_cnt, 10'd0);
      chk_eq("t6_fc", o_frame_cnt, 10'd0);
      chk_eq("t6_tready", o_rxd_tready, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_eq("t6_tready_rel", o_rxd_tready, 1'b1);
      rd_mode = 1;
      send_frame(6, 0, 32'h8000, 1'b0, 0);
      wait_drain("t6_drain");
      chk_eq("t6_fc_end", o_frame_cnt, 10'd0);
      chk_eq("t6_wr_cnt_end", o_wr_cnt, 10'd0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
